// File: rtl/multi_edge_detector.sv
// Per-channel synchronize / filter / edge-detect with sticky event flags.
// Optional debounce filter is enabled by defining MULTI_EDGE_DEBOUNCE_EN.
module multi_edge_detector #(
  parameter int CHANNELS        = 4,
  parameter int DEBOUNCE_CYCLES = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] signal,
  input  logic [1:0]          mode,
  input  logic [CHANNELS-1:0] clear,
  output logic [CHANNELS-1:0] level,
  output logic [CHANNELS-1:0] outedge,
  output logic [CHANNELS-1:0] event_flags,
  output logic                any_event
);

  logic [CHANNELS-1:0] s1;
  logic [CHANNELS-1:0] s2;
  logic [CHANNELS-1:0] edge_q;
  logic [CHANNELS-1:0] level_nxt;
  logic [CHANNELS-1:0] edge_det;
  logic [1:0]          prime;
  logic                primed;
  logic                allow_rise;
  logic                allow_fall;

  assign primed     = prime[1];
  assign allow_rise = (mode == 2'b00) || (mode == 2'b10);
  assign allow_fall = (mode == 2'b01) || (mode == 2'b10);

`ifdef MULTI_EDGE_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [CHANNELS-1:0][CW-1:0] cnt;
  logic [CHANNELS-1:0][CW-1:0] cnt_nxt;

  always_comb begin
    level_nxt = level;
    cnt_nxt   = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (!primed) begin
        level_nxt[i] = s1[i];
      end else if (s2[i] != level[i]) begin
        if (cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
          level_nxt[i] = s2[i];
        end else begin
          cnt_nxt[i] = cnt[i] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_nxt;
    end
  end
`else
  // While priming, level takes the value s2 is loading this edge, so the
  // filter is aligned with s2 by the time detection is enabled.
  always_comb begin
    level_nxt = primed ? s2 : s1;
  end
`endif

  always_comb begin
    edge_det = '0;
    if (primed) begin
      edge_det = (level_nxt ^ level) &
                 ((level_nxt & {CHANNELS{allow_rise}}) |
                  (~level_nxt & {CHANNELS{allow_fall}}));
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      s1          <= '0;
      s2          <= '0;
      level       <= '0;
      edge_q      <= '0;
      outedge     <= '0;
      event_flags <= '0;
      any_event   <= 1'b0;
      prime       <= 2'd0;
    end else begin
      s1          <= signal;
      s2          <= s1;
      level       <= level_nxt;
      edge_q      <= edge_det;
      outedge     <= edge_q;
      // set wins over a coincident clear
      event_flags <= (event_flags & ~clear) | edge_q;
      any_event   <= |event_flags;
      if (!primed) begin
        prime <= prime + 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_multi_edge_detector.sv
// Directed + randomized bench for multi_edge_detector, checked every clock
// against a history-based reference model.
module tb_multi_edge_detector;

  localparam int CH = 4;
  localparam int DB = 3;
`ifdef MULTI_EDGE_DEBOUNCE_EN
  localparam int LAT = 6;
`else
  localparam int LAT = 4;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [CH-1:0] signal;
  logic [1:0]    mode;
  logic [CH-1:0] clear;
  logic [CH-1:0] level;
  logic [CH-1:0] outedge;
  logic [CH-1:0] event_flags;
  logic          any_event;

  multi_edge_detector #(.CHANNELS(CH), .DEBOUNCE_CYCLES(DB)) dut (
    .clk(clk), .reset(reset), .signal(signal), .mode(mode), .clear(clear),
    .level(level), .outedge(outedge), .event_flags(event_flags),
    .any_event(any_event)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: hist[m-1] is the input sampled at the m-th edge since
  // reset release. s2 seen at edge e is hist[e-3]; detection runs from edge 3.
  logic [CH-1:0] hist[$];
  logic [CH-1:0] m_level, m_edgeq, m_out, m_flags;
  logic          m_any;

  function automatic logic mode_allows(input logic [1:0] md, input logic rising);
    case (md)
      2'b00:   return rising;
      2'b01:   return !rising;
      2'b10:   return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [CH-1:0] model_level(input int e, input logic [CH-1:0] cur);
    logic [CH-1:0] r;
    r = cur;
    if (e < 3) begin
      r = (e >= 2) ? hist[e-2] : '0;
    end else begin
`ifdef MULTI_EDGE_DEBOUNCE_EN
      for (int c = 0; c < CH; c++) begin
        logic flip;
        flip = 1'b1;
        for (int j = 0; j < DB; j++) begin
          if (e - j < 3) flip = 1'b0;
          else if (hist[e-j-3][c] == cur[c]) flip = 1'b0;
        end
        if (flip) r[c] = ~cur[c];
      end
`else
      r = hist[e-3];
`endif
    end
    return r;
  endfunction

  always @(posedge clk) begin
    logic [CH-1:0] nl, det;
    int e;
    if (!reset) begin
      hist.delete();
      m_level = '0; m_edgeq = '0; m_out = '0; m_flags = '0; m_any = 1'b0;
    end else begin
      hist.push_back(signal);
      e  = hist.size();
      nl = model_level(e, m_level);
      det = '0;
      if (e >= 3) begin
        for (int c = 0; c < CH; c++) begin
          if (nl[c] != m_level[c] && mode_allows(mode, nl[c])) det[c] = 1'b1;
        end
      end
      m_any   = |m_flags;
      m_flags = (m_flags & ~clear) | m_edgeq;
      m_out   = m_edgeq;
      m_edgeq = det;
      m_level = nl;
    end
    #1;
    chk("level",       32'(level),       32'(m_level));
    chk("outedge",     32'(outedge),     32'(m_out));
    chk("event_flags", 32'(event_flags), 32'(m_flags));
    chk("any_event",   32'(any_event),   32'(m_any));
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tick_count(input int n, input int c, output int pulses);
    pulses = 0;
    repeat (n) begin
      @(negedge clk);
      if (outedge[c]) pulses++;
    end
  endtask

  initial begin
    int pulses;
    logic [CH-1:0] saved;
    reset = 1'b0; signal = 4'hF; mode = 2'b00; clear = '0;

    // priming from a high input
    tick(5);
    reset = 1'b1;
    tick(3);
    chk("prime_level", 32'(level), 32'hF);
    chk("prime_edge",  32'(outedge), 32'h0);
    chk("prime_flags", 32'(event_flags), 32'h0);
    signal = 4'h0;
    tick(10);
    clear = 4'hF; tick(1); clear = '0; tick(2);

    // mode 00 rising on ch0, then a return that must not pulse
    mode = 2'b00;
    signal[0] = 1'b1;
    tick(LAT);
    chk("rise_pulse", 32'(outedge), 32'h1);
    tick(1);
    chk("rise_single", 32'(outedge), 32'h0);
    chk("rise_flag", 32'(event_flags), 32'h1);
    signal[0] = 1'b0;
    tick_count(10, 0, pulses);
    chk("fall_nopulse", 32'(pulses), 32'd0);

    // mode 10 both edges on ch2
    mode = 2'b10;
    signal[2] = 1'b1;
    tick_count(5, 2, pulses);
    begin
      int p2;
      signal[2] = 1'b0;
      tick_count(5 + LAT, 2, p2);
      pulses += p2;
    end
    chk("both_pulses", 32'(pulses), 32'd2);
    chk("both_any", 32'(any_event), 32'd1);

`ifdef MULTI_EDGE_DEBOUNCE_EN
    // debounce: 2-cycle glitch rejected, 4-cycle hold accepted
    signal[1] = 1'b1; tick(2); signal[1] = 1'b0;
    tick_count(8, 1, pulses);
    chk("glitch_pulse", 32'(pulses), 32'd0);
    chk("glitch_level", 32'(level[1]), 32'd0);
    signal[1] = 1'b1;
    tick(4);
    chk("hold_level_early", 32'(level[1]), 32'd0);
    tick(1);
    chk("hold_level", 32'(level[1]), 32'd1);
    signal[1] = 1'b0;
    tick(10);
`endif

    // flag clearing and set-wins
    clear = 4'hF; tick(1); clear = '0; tick(1);
    signal[1:0] = 2'b11;
    tick(LAT + 2);
    chk("flags_0011", 32'(event_flags), 32'h3);
    clear = 4'b0001; tick(1); clear = '0;
    chk("flags_0010", 32'(event_flags), 32'h2);
    signal[1] = 1'b0;
    tick(LAT - 1);
    clear = 4'b0010; tick(1); clear = '0;
    chk("set_wins", 32'(event_flags[1]), 32'd1);
    tick(3);

    // mode 11 suppresses detection, flags hold
    mode = 2'b11;
    saved = event_flags;
    for (int k = 0; k < 4; k++) begin
      signal = ~signal;
      tick_count(LAT + 2, 0, pulses);
    end
    chk("dis_flags", 32'(event_flags), 32'(saved));
    chk("dis_edge", 32'(outedge), 32'h0);

    // reset in the middle of a filter count
    mode = 2'b10;
    signal = ~level;
    tick(3);
    reset = 1'b0;
    tick(1);
    chk("rst_all", {level, outedge, event_flags, 3'b0, any_event}, 32'h0);
    signal = 4'hF;
    tick(2);
    reset = 1'b1;
    tick(LAT + 4);
    chk("rst_noflag", 32'(event_flags), 32'h0);

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      for (int c = 0; c < CH; c++) begin
        if ($urandom_range(0, 3) == 0) signal[c] = ~signal[c];
      end
      if ($urandom_range(0, 31) == 0) mode = 2'($urandom);
      clear = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'h0;
      reset = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
      tick(1);
    end
    reset = 1'b1; clear = '0;
    tick(4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
